// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: MEM/WB write requests, debug write handshake and
// the single register-file write port.
//   master : pipeline/debug side (drives requests, observes grant/stall/rf port)
//   slave  : arbiter side (consumes requests, drives grant/stall/rf port)
interface wb_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      reg_a_wr_en;
  logic [REG_ADDR_WIDTH-1:0] reg_a_wr_addr;
  logic [DATA_WIDTH-1:0]     reg_a_wr_data;
  logic                      reg_b_wr_en;
  logic [REG_ADDR_WIDTH-1:0] reg_b_wr_addr;
  logic [DATA_WIDTH-1:0]     reg_b_wr_data;
  logic                      dbg_valid;
  logic [REG_ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0]     dbg_data;
  logic                      dbg_ready;
  logic                      wb_stall;
  logic                      rf_wr_en;
  logic [REG_ADDR_WIDTH-1:0] rf_wr_addr;
  logic [DATA_WIDTH-1:0]     rf_wr_data;

  modport master (
    output reg_a_wr_en, reg_a_wr_addr, reg_a_wr_data,
    output reg_b_wr_en, reg_b_wr_addr, reg_b_wr_data,
    output dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready, wb_stall,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    input  reg_a_wr_en, reg_a_wr_addr, reg_a_wr_data,
    input  reg_b_wr_en, reg_b_wr_addr, reg_b_wr_data,
    input  dbg_valid, dbg_addr, dbg_data,
    output dbg_ready, wb_stall,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back scheduler for a single-write-port register file.
// Serializes dual-destination instructions (A then buffered B, one stall
// cycle), shares the port with a debug requester that is forced a slot after
// STARVE_LIMIT refused cycles, and counts stall cycles (saturating).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : MEM/WB A/B requests, debug valid/ready, rf write port,
//                      wb_stall (all grant/stall/rf outputs combinational)
//   o_stall_cycles   : saturating count of cycles with wb_stall=1
module wb_port_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_port_arbiter_if.slave     bus,
  output logic [CNT_WIDTH-1:0] o_stall_cycles
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    S_IDLE,
    S_B_PEND
  } state_e;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [WAIT_W-1:0]         r_wait_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_b_addr;
  logic [DATA_WIDTH-1:0]     r_b_data;
  logic [CNT_WIDTH-1:0]      r_stall_cycles;

  logic                      w_a_req_raw;
  logic                      w_a_req;
  logic                      w_b_req;
  logic                      w_starve;
  logic                      w_capture;
  logic                      w_dbg_ready;
  logic                      w_wb_stall;
  logic                      w_rf_wr_en;
  logic [REG_ADDR_WIDTH-1:0] w_rf_wr_addr;
  logic [DATA_WIDTH-1:0]     w_rf_wr_data;

  // Effective requests; r0 writes are discarded, and a same-address dual
  // write collapses to B alone (B is the later result).
  assign w_a_req_raw = bus.reg_a_wr_en && (bus.reg_a_wr_addr != '0);
  assign w_b_req     = bus.reg_b_wr_en && (bus.reg_b_wr_addr != '0);
  assign w_a_req     = w_a_req_raw &&
                       !(w_b_req && (bus.reg_a_wr_addr == bus.reg_b_wr_addr));
  assign w_starve    = bus.dbg_valid && (r_wait_cnt == WAIT_W'(STARVE_LIMIT));

  // Next-state and combinational port control; everything idles in reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_dbg_ready  = 1'b0;
    w_wb_stall   = 1'b0;
    w_rf_wr_en   = 1'b0;
    w_rf_wr_addr = '0;
    w_rf_wr_data = '0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_starve) begin
            // Forced debug slot: the pipeline instruction is held and
            // re-evaluated next cycle.
            w_dbg_ready = 1'b1;
            w_wb_stall  = w_a_req || w_b_req;
          end else if (w_a_req && w_b_req) begin
            w_rf_wr_en   = 1'b1;
            w_rf_wr_addr = bus.reg_a_wr_addr;
            w_rf_wr_data = bus.reg_a_wr_data;
            w_wb_stall   = 1'b1;
            w_capture    = 1'b1;
            w_state_nxt  = S_B_PEND;
          end else if (w_a_req) begin
            w_rf_wr_en   = 1'b1;
            w_rf_wr_addr = bus.reg_a_wr_addr;
            w_rf_wr_data = bus.reg_a_wr_data;
          end else if (w_b_req) begin
            w_rf_wr_en   = 1'b1;
            w_rf_wr_addr = bus.reg_b_wr_addr;
            w_rf_wr_data = bus.reg_b_wr_data;
          end else if (bus.dbg_valid) begin
            w_dbg_ready = 1'b1;
          end
        end
        S_B_PEND: begin
          // Second half of a dual write; inputs are ignored this cycle.
          w_rf_wr_en   = 1'b1;
          w_rf_wr_addr = r_b_addr;
          w_rf_wr_data = r_b_data;
          w_state_nxt  = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase

      // A debug write to r0 completes the handshake without touching the RF.
      if (w_dbg_ready && (bus.dbg_addr != '0)) begin
        w_rf_wr_en   = 1'b1;
        w_rf_wr_addr = bus.dbg_addr;
        w_rf_wr_data = bus.dbg_data;
      end
    end
  end

  // State, pending-B buffer, starvation counter and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= '0;
      r_b_addr       <= '0;
      r_b_data       <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_capture) begin
        r_b_addr <= bus.reg_b_wr_addr;
        r_b_data <= bus.reg_b_wr_data;
      end

      if (!bus.dbg_valid || w_dbg_ready) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_W'(STARVE_LIMIT)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      if (w_wb_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.dbg_ready  = w_dbg_ready;
  assign bus.wb_stall   = w_wb_stall;
  assign bus.rf_wr_en   = w_rf_wr_en;
  assign bus.rf_wr_addr = w_rf_wr_addr;
  assign bus.rf_wr_data = w_rf_wr_data;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-cycle expectations are queued as
// stimulus is applied and compared against the write port at the negedge.
module tb_wb_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 32;

  typedef struct {
    string          tag;
    logic           en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic           stall;
    logic           rdy;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] stall_cycles;
  exp_t          sb_q[$];
  int            n_checks;
  int            n_errors;

  wb_port_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  wb_port_arbiter #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(AW),
    .STARVE_LIMIT  (4),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ae, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic be, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bus.reg_a_wr_en   = ae;
    bus.reg_a_wr_addr = aa;
    bus.reg_a_wr_data = ad;
    bus.reg_b_wr_en   = be;
    bus.reg_b_wr_addr = ba;
    bus.reg_b_wr_data = bd;
    bus.dbg_valid     = dv;
    bus.dbg_addr      = da;
    bus.dbg_data      = dd;
  endtask

  task automatic expect_cyc(input string tag, input logic en, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic stall, input logic rdy);
    exp_t e;
    e.tag = tag; e.en = en; e.addr = addr; e.data = data; e.stall = stall; e.rdy = rdy;
    sb_q.push_back(e);
  endtask

  // Compare this cycle's port against the oldest expectation, then advance
  // to just after the next posedge.
  task automatic run_cycle();
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_en"},    32'(bus.rf_wr_en),   32'(e.en));
      chk({e.tag, "_addr"},  32'(bus.rf_wr_addr), 32'(e.addr));
      chk({e.tag, "_data"},  32'(bus.rf_wr_data), 32'(e.data));
      chk({e.tag, "_stall"}, 32'(bus.wb_stall),   32'(e.stall));
      chk({e.tag, "_rdy"},   32'(bus.dbg_ready),  32'(e.rdy));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 5'd9, 32'hAB);
    #2;
    // Outputs forced idle in reset even with live requests.
    chk("rst_en",    32'(bus.rf_wr_en),  32'd0);
    chk("rst_stall", 32'(bus.wb_stall),  32'd0);
    chk("rst_rdy",   32'(bus.dbg_ready), 32'd0);
    chk("rst_addr",  32'(bus.rf_wr_addr), 32'd0);
    chk("rst_cnt",   stall_cycles,       32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Dual write: A with stall, then buffered B.
    drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, 0);
    expect_cyc("dual_a", 1, 5'd3, 32'h11, 1, 0);
    run_cycle();
    expect_cyc("dual_b", 1, 5'd4, 32'h22, 0, 0);
    run_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_cyc("idle0", 0, 0, 0, 0, 0);
    run_cycle();
    chk("cnt_dual", stall_cycles, 32'd1);

    // A to r0: B alone. Same address: B wins.
    drive(1, 5'd0, 32'h5, 1, 5'd7, 32'h9, 0, 0, 0);
    expect_cyc("a_r0", 1, 5'd7, 32'h9, 0, 0);
    run_cycle();
    drive(1, 5'd2, 32'h1, 1, 5'd2, 32'h2, 0, 0, 0);
    expect_cyc("same_addr", 1, 5'd2, 32'h2, 0, 0);
    run_cycle();

    // Debug only, then debug to r0.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'hAB);
    expect_cyc("dbg_r9", 1, 5'd9, 32'hAB, 0, 1);
    run_cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hAB);
    expect_cyc("dbg_r0", 0, 0, 0, 0, 1);
    run_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_cyc("idle1", 0, 0, 0, 0, 0);
    run_cycle();
    chk("cnt_nostall", stall_cycles, 32'd1);

    // Starvation: four refused cycles, forced slot, then held write.
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd5, 32'h100 + 32'(i), 0, 0, 0, 1, 5'd10, 32'hCD);
      expect_cyc("starve_refuse", 1, 5'd5, 32'h100 + 32'(i), 0, 0);
      run_cycle();
    end
    drive(1, 5'd5, 32'h104, 0, 0, 0, 1, 5'd10, 32'hCD);
    expect_cyc("starve_grant", 1, 5'd10, 32'hCD, 1, 1);
    run_cycle();
    drive(1, 5'd5, 32'h104, 0, 0, 0, 0, 0, 0);
    expect_cyc("starve_held", 1, 5'd5, 32'h104, 0, 0);
    run_cycle();
    chk("cnt_starve", stall_cycles, 32'd2);

    // Starvation limit reached in B_PEND: B first, debug next cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd6, 32'h200 + 32'(i), 0, 0, 0, 1, 5'd11, 32'hEE);
      expect_cyc("bp_refuse", 1, 5'd6, 32'h200 + 32'(i), 0, 0);
      run_cycle();
    end
    drive(1, 5'd12, 32'h31, 1, 5'd13, 32'h32, 1, 5'd11, 32'hEE);
    expect_cyc("bp_dual_a", 1, 5'd12, 32'h31, 1, 0);
    run_cycle();
    expect_cyc("bp_dual_b", 1, 5'd13, 32'h32, 0, 0);
    run_cycle();
    drive(1, 5'd14, 32'h41, 0, 0, 0, 1, 5'd11, 32'hEE);
    expect_cyc("bp_dbg_grant", 1, 5'd11, 32'hEE, 1, 1);
    run_cycle();
    drive(1, 5'd14, 32'h41, 0, 0, 0, 0, 0, 0);
    expect_cyc("bp_held", 1, 5'd14, 32'h41, 0, 0);
    run_cycle();
    chk("cnt_bp", stall_cycles, 32'd4);

    // Reset while in B_PEND discards the pending B write.
    drive(1, 5'd1, 32'h71, 1, 5'd2, 32'h72, 0, 0, 0);
    expect_cyc("rst_dual_a", 1, 5'd1, 32'h71, 1, 0);
    run_cycle();
    rst_n = 1'b0;
    #1;
    chk("rstbp_en",    32'(bus.rf_wr_en),  32'd0);
    chk("rstbp_stall", 32'(bus.wb_stall),  32'd0);
    chk("rstbp_data",  bus.rf_wr_data,     32'd0);
    chk("rstbp_cnt",   stall_cycles,       32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_cyc("rst_no_b", 0, 0, 0, 0, 0);
    run_cycle();
    chk("cnt_after_rst", stall_cycles, 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
